mahoa_83_uutien_ack: RTL

- Sequential 8-to-3 priority encoder with request latching and a valid/acknowledge output handshake.
- It is the encode-side counterpart of the 3-to-8 select decoder (GIAIMA family).
- Collects one-hot or multi-hot request lines into a pending register and issues one 3-bit code per request, highest index first.
- Each code is held until the consumer acknowledges it; the consumer is typically the decoder stage or a control FSM.

---
 rtl/mahoa_pkg.sv | 28 ++
 rtl/uutien_83_comb.sv | 16 +
 rtl/mahoa_83_uutien_ack.sv | 85 ++++++++
 3 files changed

// File: rtl/mahoa_pkg.sv
// Shared types and helpers for the 8-to-3 priority encoder with ack handshake.
// The priority function is the single definition used by the select sub-module.
package mahoa_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned W_CODE = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Last hit in scan order wins, so the scan runs from lowest to highest priority.
  function automatic logic [W_CODE-1:0] prio_idx(input logic [N_REQ-1:0] vec,
                                                 input logic             msb_first);
    logic [W_CODE-1:0] idx;
    idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (msb_first) begin
        if (vec[k]) idx = W_CODE'(k);
      end else begin
        if (vec[N_REQ-1-k]) idx = W_CODE'(N_REQ-1-k);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/uutien_83_comb.sv
// Pure combinational priority select: index of the highest-priority set bit
// of vec, plus a nonzero flag.
module uutien_83_comb
  import mahoa_pkg::*;
#(
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic [N_REQ-1:0]  vec,
  output logic [W_CODE-1:0] idx,
  output logic              any
);

  assign idx = prio_idx(vec, MSB_FIRST != 0);
  assign any = |vec;

endmodule

// File: rtl/mahoa_83_uutien_ack.sv
// Sequential 8-to-3 priority encoder: requests latch into a pending register
// and are issued one code at a time, each held until ACK.
module mahoa_83_uutien_ack #(
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned N_REQ     = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             E,
  input  logic [N_REQ-1:0] I,
  input  logic             ACK,
  output logic [2:0]       O,
  output logic             V,
  output logic             GS,
  output logic             EO
);
  import mahoa_pkg::*;

  if (N_REQ != 8) begin : g_n_req_check
    $error("mahoa_83_uutien_ack: N_REQ must be 8 for a 3-bit code");
  end

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  p_q, p_d, clr, pn;
  logic [W_CODE-1:0] o_d, sel;
  logic              accept, any, gs_d, eo_d;

  // Only the code being accepted is cleared; a fresh request on the same
  // line re-sets it in the same edge, so set wins over clear.
  always_comb begin
    accept = (state_q == OFFER) && ACK;
    clr    = accept ? (N_REQ'(1) << O) : '0;
    pn     = p_q & ~clr;
    p_d    = pn | (E ? I : '0);
  end

  uutien_83_comb #(
    .MSB_FIRST(MSB_FIRST)
  ) u_sel (
    .vec(pn),
    .idx(sel),
    .any(any)
  );

  always_comb begin
    state_d = state_q;
    o_d     = O;
    case (state_q)
      IDLE: begin
        if (any) begin
          o_d     = sel;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (ACK) begin
          if (any) o_d = sel;
          else     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    gs_d = (p_d != '0) || (state_d == OFFER);
    eo_d = E && !gs_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      p_q     <= '0;
      O       <= '0;
      GS      <= 1'b0;
      EO      <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      O       <= o_d;
      GS      <= gs_d;
      EO      <= eo_d;
    end
  end

  assign V = (state_q == OFFER);

endmodule
